// File: rtl/pairwise_compare_sequencer_if.sv
// ---------------------------------------------------------------------------
// pairwise_compare_sequencer_if
//
// Bundles the start/done handshake, the operands and the result flags of the
// pairwise compare sequencer.
//
//   start        request a comparison (honoured only while busy = 0)
//   signed_mode  1 = two's-complement compare, 0 = unsigned
//   a, b         WIDTH-bit operands, sampled on the accepting edge
//   busy         high while a comparison is in progress
//   done         one-cycle pulse when gt/eq/lt become valid
//   gt, eq, lt   registered result flags, one-hot after a comparison
//
// Modports:
//   master  drives the request side (operand registers / switches)
//   slave   the comparator itself
// ---------------------------------------------------------------------------
interface pairwise_compare_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;

    modport master (
        output start,
        output signed_mode,
        output a,
        output b,
        input  busy,
        input  done,
        input  gt,
        input  eq,
        input  lt
    );

    modport slave (
        input  start,
        input  signed_mode,
        input  a,
        input  b,
        output busy,
        output done,
        output gt,
        output eq,
        output lt
    );
endinterface

// File: rtl/pairwise_compare_sequencer.sv
// ---------------------------------------------------------------------------
// pairwise_compare_sequencer
//
// Sequential magnitude comparator. Instead of one flat WIDTH-bit comparator,
// a single 2-bit greater/less slice is stepped over the operands, most
// significant pair first, and the walk stops at the first pair that differs.
// A comparison takes k cycles, where k is the number of pairs examined
// (1 <= k <= WIDTH/2).
//
// Parameters:
//   WIDTH   operand width, must be even and >= 2
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset; aborts a comparison without done
//   bus     pairwise_compare_sequencer_if.slave
//             start/signed_mode/a/b in, busy/done/gt/eq/lt out
// ---------------------------------------------------------------------------
module pairwise_compare_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pairwise_compare_sequencer_if.slave   bus
);

    localparam int S     = WIDTH / 2;
    localparam int IDX_W = (S > 1) ? $clog2(S) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(S - 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    // 2-bit magnitude slice; returns {greater, less}. Equal is implied when
    // both are zero.
    function automatic logic [1:0] slice_cmp(input logic [1:0] x,
                                             input logic [1:0] y);
        logic g;
        logic l;
        g = (x[1] & ~y[1]) | (x[0] & ~y[1] & ~y[0]) | (x[1] & x[0] & ~y[0]);
        l = (~x[1] & y[1]) | (~x[1] & ~x[0] & y[0]) | (~x[0] & y[1] & y[0]);
        return {g, l};
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             smode_q, smode_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             done_q, done_d;

    logic [1:0]       pair_a;
    logic [1:0]       pair_b;
    logic             slice_gt;
    logic             slice_lt;
    logic             slice_eq;

    // Current slice. In signed mode the sign bits of the top pair are
    // inverted, which maps two's-complement onto offset binary so the same
    // unsigned slice orders the operands correctly.
    always_comb begin
        pair_a = a_q[{idx_q, 1'b0} +: 2];
        pair_b = b_q[{idx_q, 1'b0} +: 2];
        if (smode_q && (idx_q == IDX_TOP)) begin
            pair_a[1] = ~pair_a[1];
            pair_b[1] = ~pair_b[1];
        end
        {slice_gt, slice_lt} = slice_cmp(pair_a, pair_b);
        slice_eq = ~slice_gt & ~slice_lt;
    end

    // Next-state and result logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        smode_d = smode_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Also taken in the done cycle, so a held start restarts
                // immediately and wipes the previous result.
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    smode_d = bus.signed_mode;
                    idx_d   = IDX_TOP;
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = COMPARE;
                end
            end

            COMPARE: begin
                if (slice_gt) begin
                    gt_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (slice_lt) begin
                    lt_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (slice_eq && (idx_q == '0)) begin
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            smode_q <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            smode_q <= smode_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            done_q  <= done_d;
        end
    end

    // busy is decoded straight from the state register, so it is glitch-free
    // and drops asynchronously with reset.
    assign bus.busy = (state_q == COMPARE);
    assign bus.done = done_q;
    assign bus.gt   = gt_q;
    assign bus.eq   = eq_q;
    assign bus.lt   = lt_q;

endmodule
